// File: rtl/mips_control_unit.sv
// Main control decoder for the MIPS-subset CPU: opcode -> registered datapath control strobes.
// Latency: 1 cycle (outputs reflect op sampled at the previous rising clk edge).
// Backpressure: none; the block updates every cycle with no enable or handshake.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; all outputs 0 (safe NOP)
//   op        instruction opcode field instr[31:26]
//   regdst    1 = write rd, 0 = write rt
//   regwr     register-file write enable
//   alusrc    1 = ALU operand B is the extended immediate
//   memwr     data-memory write enable
//   memtoreg  1 = writeback from memory
//   jump      select jump target for next PC
//   branch    beq qualifier
//   aluop     000 add, 001 sub, 010 or, 100 funct-decoded
//   rtype     ALU control decodes the funct field
//   extop     1 = sign-extend imm16
//   illegal   opcode not in the supported set
module mips_control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  output logic       regdst,
  output logic       regwr,
  output logic       alusrc,
  output logic       memwr,
  output logic       memtoreg,
  output logic       jump,
  output logic       branch,
  output logic [2:0] aluop,
  output logic       rtype,
  output logic       extop,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_FUNCT = 3'b100;

  logic       regdst_d,   regdst_q;
  logic       regwr_d,    regwr_q;
  logic       alusrc_d,   alusrc_q;
  logic       memwr_d,    memwr_q;
  logic       memtoreg_d, memtoreg_q;
  logic       jump_d,     jump_q;
  logic       branch_d,   branch_q;
  logic [2:0] aluop_d,    aluop_q;
  logic       rtype_d,    rtype_q;
  logic       extop_d,    extop_q;
  logic       illegal_d,  illegal_q;

  // All strobes default to 0 so any unmatched opcode (including X/Z in
  // simulation, which matches no case item) decodes as a NOP flagged illegal.
  always_comb begin
    regdst_d   = 1'b0;
    regwr_d    = 1'b0;
    alusrc_d   = 1'b0;
    memwr_d    = 1'b0;
    memtoreg_d = 1'b0;
    jump_d     = 1'b0;
    branch_d   = 1'b0;
    aluop_d    = ALU_ADD;
    rtype_d    = 1'b0;
    extop_d    = 1'b0;
    illegal_d  = 1'b0;
    case (op)
      OP_RTYPE: begin
        regdst_d = 1'b1;
        regwr_d  = 1'b1;
        aluop_d  = ALU_FUNCT;
        rtype_d  = 1'b1;
      end
      OP_ORI: begin
        // Logical immediate: zero-extended.
        regwr_d  = 1'b1;
        alusrc_d = 1'b1;
        aluop_d  = ALU_OR;
      end
      OP_ADDIU: begin
        regwr_d  = 1'b1;
        alusrc_d = 1'b1;
        extop_d  = 1'b1;
      end
      OP_LW: begin
        regwr_d    = 1'b1;
        alusrc_d   = 1'b1;
        memtoreg_d = 1'b1;
        extop_d    = 1'b1;
      end
      OP_SW: begin
        alusrc_d = 1'b1;
        memwr_d  = 1'b1;
        extop_d  = 1'b1;
      end
      OP_BEQ: begin
        // Subtract for the equality compare; offset is sign-extended.
        branch_d = 1'b1;
        aluop_d  = ALU_SUB;
        extop_d  = 1'b1;
      end
      OP_J: begin
        jump_d = 1'b1;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regdst_q   <= 1'b0;
      regwr_q    <= 1'b0;
      alusrc_q   <= 1'b0;
      memwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      jump_q     <= 1'b0;
      branch_q   <= 1'b0;
      aluop_q    <= 3'b000;
      rtype_q    <= 1'b0;
      extop_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      regdst_q   <= regdst_d;
      regwr_q    <= regwr_d;
      alusrc_q   <= alusrc_d;
      memwr_q    <= memwr_d;
      memtoreg_q <= memtoreg_d;
      jump_q     <= jump_d;
      branch_q   <= branch_d;
      aluop_q    <= aluop_d;
      rtype_q    <= rtype_d;
      extop_q    <= extop_d;
      illegal_q  <= illegal_d;
    end
  end

  assign regdst   = regdst_q;
  assign regwr    = regwr_q;
  assign alusrc   = alusrc_q;
  assign memwr    = memwr_q;
  assign memtoreg = memtoreg_q;
  assign jump     = jump_q;
  assign branch   = branch_q;
  assign aluop    = aluop_q;
  assign rtype    = rtype_q;
  assign extop    = extop_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed and randomized check of the registered MIPS control decoder.
// Control vector order: regdst,regwr,alusrc,memwr,memtoreg,jump,branch,aluop[2:0],rtype,extop,illegal
module tb_mips_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       regdst, regwr, alusrc, memwr, memtoreg, jump, branch;
  logic [2:0] aluop;
  logic       rtype, extop, illegal;

  int checks = 0;
  int errors = 0;

  // Hand-computed control vectors from the decode table.
  localparam logic [12:0] V_ZERO  = 13'b0000000_000_000;
  localparam logic [12:0] V_RTYPE = 13'b1100000_100_100;
  localparam logic [12:0] V_ORI   = 13'b0110000_010_000;
  localparam logic [12:0] V_ADDIU = 13'b0110000_000_010;
  localparam logic [12:0] V_LW    = 13'b0110100_000_010;
  localparam logic [12:0] V_SW    = 13'b0011000_000_010;
  localparam logic [12:0] V_BEQ   = 13'b0000001_001_010;
  localparam logic [12:0] V_J     = 13'b0000010_000_000;
  localparam logic [12:0] V_ILL   = 13'b0000000_000_001;

  mips_control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .regdst   (regdst),
    .regwr    (regwr),
    .alusrc   (alusrc),
    .memwr    (memwr),
    .memtoreg (memtoreg),
    .jump     (jump),
    .branch   (branch),
    .aluop    (aluop),
    .rtype    (rtype),
    .extop    (extop),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] obs_vec();
    return {regdst, regwr, alusrc, memwr, memtoreg, jump, branch, aluop, rtype, extop, illegal};
  endfunction

  function automatic logic [12:0] ref_vec(input logic [5:0] o);
    case (o)
      6'b000000: return V_RTYPE;
      6'b001101: return V_ORI;
      6'b001001: return V_ADDIU;
      6'b100011: return V_LW;
      6'b101011: return V_SW;
      6'b000100: return V_BEQ;
      6'b000010: return V_J;
      default:   return V_ILL;
    endcase
  endfunction

  task automatic check_vec(input string tag, input logic [12:0] observed, input logic [12:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  task automatic check_bits(input string tag, input logic [2:0] observed, input logic [2:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  // Apply op, clock once, sample 1 time unit after the edge.
  task automatic step(input logic [5:0] v);
    op = v;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] legal_ops [7] = '{6'b000000, 6'b001101, 6'b001001, 6'b100011,
                                6'b101011, 6'b000100, 6'b000010};

  initial begin
    rst_n = 1'b0;
    op    = 6'b000000;

    // Reset held across several edges.
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_hold", obs_vec(), V_ZERO);

    // Release between edges; the first edge samples op.
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_vec("reset_release_rtype", obs_vec(), V_RTYPE);

    // Opcode sweep.
    step(6'b000000); check_vec("sweep_rtype", obs_vec(), V_RTYPE);
    step(6'b001101); check_vec("sweep_ori", obs_vec(), V_ORI);
    check_bits("ori_aluop", aluop, 3'b010);
    check_bits("ori_extop", {2'b00, extop}, 3'b000);
    step(6'b001001); check_vec("sweep_addiu", obs_vec(), V_ADDIU);
    step(6'b100011); check_vec("sweep_lw", obs_vec(), V_LW);
    check_bits("lw_memtoreg", {2'b00, memtoreg}, 3'b001);
    step(6'b101011); check_vec("sweep_sw", obs_vec(), V_SW);
    check_bits("sw_memwr_regwr", {1'b0, memwr, regwr}, 3'b010);
    step(6'b000100); check_vec("sweep_beq", obs_vec(), V_BEQ);
    check_bits("beq_aluop", aluop, 3'b001);
    step(6'b000010); check_vec("sweep_j", obs_vec(), V_J);

    // Illegal opcodes, then recovery.
    step(6'b111111); check_vec("illegal_111111", obs_vec(), V_ILL);
    step(6'b001000); check_vec("illegal_001000", obs_vec(), V_ILL);
    step(6'b000011); check_vec("illegal_000011", obs_vec(), V_ILL);
    step(6'b100011); check_vec("illegal_recover_lw", obs_vec(), V_LW);

    // Latency: a mid-cycle op change must not show until the next edge.
    step(6'b101011); check_vec("latency_sw", obs_vec(), V_SW);
    #2 op = 6'b100011;
    #1 check_vec("latency_hold", obs_vec(), V_SW);
    @(posedge clk);
    #1 check_vec("latency_lw", obs_vec(), V_LW);

    // Mid-run asynchronous reset with sw registered.
    step(6'b101011); check_bits("midrst_memwr_before", {2'b00, memwr}, 3'b001);
    #2 rst_n = 1'b0;
    #1 check_vec("midrst_cleared", obs_vec(), V_ZERO);
    #1 rst_n = 1'b1;
    #1 check_vec("midrst_still_zero", obs_vec(), V_ZERO);
    @(posedge clk);
    #1 check_bits("midrst_memwr_restored", {2'b00, memwr}, 3'b001);

    // Randomized opcodes, half drawn from the legal set.
    for (int i = 0; i < 1000; i++) begin
      logic [5:0] v;
      if ($urandom_range(1, 0) == 1)
        v = legal_ops[$urandom_range(6, 0)];
      else
        v = 6'($urandom);
      step(v);
      check_vec($sformatf("rand_%0d_op_%b", i, v), obs_vec(), ref_vec(v));
      check_bits("inv_regwr_memwr", {2'b00, regwr & memwr}, 3'b000);
      check_bits("inv_jump_branch", {2'b00, jump & branch}, 3'b000);
      check_bits("inv_memtoreg_regwr", {2'b00, memtoreg & ~regwr}, 3'b000);
      check_bits("inv_rtype_aluop", {2'b00, rtype}, {2'b00, aluop == 3'b100});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_control_unit.md
Name: mips_control_unit

Overview:
- Main control decoder for the team's MIPS-subset CPU.
- Decodes the 6-bit instruction opcode into datapath control strobes: register-file destination and write enable, ALU source, memory write, writeback mux, jump, branch, ALU operation class, R-type flag and immediate-extension mode.
- Outputs are registered, so the block acts as the control portion of a decode-stage pipeline register.
- Supported opcodes: R-type, ori, addiu, lw, sw, beq, j.

Parameters:
- None.

Ports:
- clk       input   1  system clock, rising edge active
- rst_n     input   1  asynchronous active-low reset
- op        input   6  instruction opcode field (instr[31:26])
- regdst    output  1  1 = write rd, 0 = write rt
- regwr     output  1  register-file write enable
- alusrc    output  1  1 = ALU operand B is extended immediate, 0 = rt data
- memwr     output  1  data-memory write enable
- memtoreg  output  1  1 = writeback from memory, 0 = from ALU
- jump      output  1  select jump target for next PC
- branch    output  1  conditional-branch (beq) qualifier
- aluop     output  3  ALU operation class (encoding below)
- rtype     output  1  1 = ALU control decodes the funct field
- extop     output  1  1 = sign-extend imm16, 0 = zero-extend
- illegal   output  1  opcode not in the supported set

Behaviour:
- Reset:
  - rst_n low forces every output to 0 immediately, with no clock needed.
  - All-zero outputs form a safe NOP: no register write and no memory write.
  - Outputs stay 0 while rst_n is low. The first rising edge after release samples op.
- Latency: purely a registered decode. Every output reflects the op sampled at the previous rising edge of clk (1-cycle latency). No enable and no handshake; the block updates every cycle.
- aluop encoding: 000 add, 001 subtract, 010 OR, 100 funct-decoded (R-type). Codes 011, 101, 110 and 111 are never produced.
- Decode table, field order regdst, regwr, alusrc, memwr, memtoreg, jump, branch, aluop, rtype, extop, illegal:
  - 000000 R-type: 1,1,0,0,0,0,0,100,1,0,0
  - 001101 ori:    0,1,1,0,0,0,0,010,0,0,0
  - 001001 addiu:  0,1,1,0,0,0,0,000,0,1,0
  - 100011 lw:     0,1,1,0,1,0,0,000,0,1,0
  - 101011 sw:     0,0,1,1,0,0,0,000,0,1,0
  - 000100 beq:    0,0,0,0,0,0,1,001,0,1,0
  - 000010 j:      0,0,0,0,0,1,0,000,0,0,0
  - any other:     all controls 0, illegal=1
- Invariants, each holding on every cycle:
  - regwr and memwr are never both 1.
  - jump and branch are never both 1.
  - memtoreg=1 only with regwr=1.
  - rtype=1 exactly when aluop=100.
- X/Z on op must not propagate as partial writes. The decode must fall into the default (illegal) branch.
- Back-to-back changes of op each cycle are decoded independently. No internal state exists beyond the output register.
- Asynchronous assertion of rst_n mid-stream clears outputs within the same cycle. Deassertion is synchronised externally; the block requires no internal sync.

Test Plan:
- Reset: hold rst_n=0 with op=000000 and toggle clk -> all outputs 0 and illegal=0. Release rst_n, one clk edge -> regdst=1, regwr=1, aluop=100, rtype=1.
- Opcode sweep, applying each op for one cycle in sequence 000000, 001101, 001001, 100011, 101011, 000100, 000010 -> outputs match the decode table one cycle later. Specific checks:
  - ori gives aluop=010, extop=0.
  - lw gives memtoreg=1.
  - sw gives memwr=1, regwr=0.
  - beq gives branch=1, aluop=001.
  - j gives jump=1 with all others 0.
- Illegal opcodes 111111, 001000 and 000011 -> every control 0, illegal=1. Then op=100011 -> illegal returns to 0 next cycle.
- Latency check: change op between clock edges (e.g. sw to lw) -> outputs unchanged until the next rising edge.
- Mid-run reset: op=101011 with memwr=1 registered, pulse rst_n low asynchronously between edges -> memwr drops to 0 immediately. After release, the next edge restores memwr=1.
- Randomized op for 1000 cycles -> invariants hold every cycle and outputs equal the table/default decode of the previous cycle's op.
